// File: rtl/fulladder_pkg.sv
// Shared definitions for the full-adder BIST: state encoding, LFSR taps,
// delay-line entry layout and the golden full-adder function.
package fulladder_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // x^8+x^6+x^5+x^4+1, left-shifting Fibonacci form: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // One slot of the expected-result delay line
  typedef struct packed {
    logic valid;
    logic cout;
    logic sum;
  } dl_entry_t;

  // Golden model, returns {cout, sum}
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

  // One LFSR step: shift left, feedback enters bit 0
  function automatic logic [7:0] lfsr_step(input logic [7:0] state);
    return {state[6:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous seed load and step enable.
module lfsr8
  import fulladder_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [7:0] i_seed,
  output logic [7:0] o_state
);

  logic [7:0] r_state;

  // Reset and load both take the seed; otherwise advance on step
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_load) begin
      r_state <= i_seed;
    end else if (i_step) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/fulladder_bist.sv
// Self-test engine for a registered 1-bit full adder: drives LFSR vectors,
// checks the adder's results against the golden model after LATENCY cycles,
// and reports counts plus a pass/fail verdict.
module fulladder_bist
  import fulladder_pkg::*;
#(
  parameter int unsigned N_VECTORS = 8,
  parameter int unsigned LATENCY   = 1,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             cin,
  input  logic             sum_in,
  input  logic             cout_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] LAST_VEC   = CNT_W'(N_VECTORS - 1);
  localparam logic [3:0]       LAST_DRAIN = 4'(LATENCY - 1);

  logic [1:0]       r_state, w_state_d;
  logic [2:0]       r_vec, w_vec_d;  // {cin, b, a}
  logic [CNT_W-1:0] r_issue_cnt, w_issue_d;
  logic [3:0]       r_drain_cnt, w_drain_d;
  logic [CNT_W-1:0] r_vec_cnt, w_vec_cnt_d;
  logic [CNT_W-1:0] r_err_cnt, w_err_cnt_d;
  logic             r_pass, w_pass_d;
  logic             r_start_q;
  logic             w_start_acc;
  logic             w_lfsr_load, w_lfsr_step;
  logic [7:0]       w_lfsr;
  logic [2:0]       w_next_vec;
  logic             w_issue;
  logic [1:0]       w_exp;
  logic             w_mismatch;
  dl_entry_t        r_dl [LATENCY];
  dl_entry_t        w_dl_out;

  lfsr8 u_lfsr (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_load    (w_lfsr_load),
    .i_step    (w_lfsr_step),
    .i_seed    (LFSR_SEED),
    .o_state   (w_lfsr)
  );

  // Only a fresh assertion starts a run, so a start held into DONE fires once
  assign w_start_acc = start && !r_start_q && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_next_vec  = 3'(lfsr_step(w_lfsr));
  assign w_issue     = (r_state == ST_RUN);
  assign w_exp       = full_add(r_vec[0], r_vec[1], r_vec[2]);
  assign w_dl_out    = r_dl[LATENCY-1];
  assign w_mismatch  = {cout_in, sum_in} != {w_dl_out.cout, w_dl_out.sum};

  // Result counters: cleared on run start, bumped on each valid compare
  always_comb begin
    w_vec_cnt_d = r_vec_cnt;
    w_err_cnt_d = r_err_cnt;
    if (w_start_acc) begin
      w_vec_cnt_d = '0;
      w_err_cnt_d = '0;
    end else if (w_dl_out.valid) begin
      w_vec_cnt_d = r_vec_cnt + CNT_W'(1);
      if (w_mismatch && !(&r_err_cnt)) begin
        w_err_cnt_d = r_err_cnt + CNT_W'(1);
      end
    end
  end

  // FSM next state, vector issue and LFSR control
  always_comb begin
    w_state_d   = r_state;
    w_vec_d     = r_vec;
    w_issue_d   = r_issue_cnt;
    w_drain_d   = r_drain_cnt;
    w_pass_d    = r_pass;
    w_lfsr_load = 1'b0;
    w_lfsr_step = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_acc) begin
          w_state_d   = ST_RUN;
          w_lfsr_load = 1'b1;
          w_vec_d     = LFSR_SEED[2:0];
          w_issue_d   = '0;
          w_pass_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (r_issue_cnt == LAST_VEC) begin
          w_state_d = ST_DRAIN;
          w_vec_d   = '0;
          w_drain_d = '0;
        end else begin
          // Present the stepped value so a/b/cin track the LFSR state
          w_lfsr_step = 1'b1;
          w_vec_d     = w_next_vec;
          w_issue_d   = r_issue_cnt + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == LAST_DRAIN) begin
          // Last compare lands on this edge, so judge the updated error count
          w_state_d = ST_DONE;
          w_pass_d  = (w_err_cnt_d == '0);
        end else begin
          w_drain_d = r_drain_cnt + 4'd1;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_vec       <= '0;
      r_issue_cnt <= '0;
      r_drain_cnt <= '0;
      r_vec_cnt   <= '0;
      r_err_cnt   <= '0;
      r_pass      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_vec       <= w_vec_d;
      r_issue_cnt <= w_issue_d;
      r_drain_cnt <= w_drain_d;
      r_vec_cnt   <= w_vec_cnt_d;
      r_err_cnt   <= w_err_cnt_d;
      r_pass      <= w_pass_d;
    end
  end

  // Expected-result delay line, aligned to the adder's latency
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int j = 0; j < LATENCY; j++) begin
        r_dl[j] <= '0;
      end
    end else begin
      r_dl[0] <= {w_issue, w_exp};
      for (int j = 1; j < LATENCY; j++) begin
        r_dl[j] <= r_dl[j-1];
      end
    end
  end

  // Start history, sampled through reset so a start held across reset is not a new request
  always_ff @(posedge clk) begin
    r_start_q <= start;
  end

  assign a       = r_vec[0];
  assign b       = r_vec[1];
  assign cin     = r_vec[2];
  assign busy    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done    = (r_state == ST_DONE);
  assign pass    = r_pass;
  assign vec_cnt = r_vec_cnt;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_fulladder_bist.sv
// Scoreboard bench for fulladder_bist: two instances (LATENCY 1 and 2) beside
// behavioural registered adders, with a fault-mode switch on the first adder.
module tb_fulladder_bist;
  import fulladder_pkg::*;

  typedef struct {
    int vec;
    int err;
    int pass;
    int busy;
  } res_t;

  // Vectors {cin,b,a} = low bits of A5,4A,95,2A,54,A9,53,A7
  localparam logic [2:0] VEC_TAB [8] = '{3'b101, 3'b010, 3'b101, 3'b010,
                                         3'b100, 3'b001, 3'b011, 3'b111};
  localparam int ERR_STUCK = 5;  // vectors with sum=1
  localparam int ERR_LAT   = 6;  // results differing from the previous vector's

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        a1, b1, cin1, sum1, cout1, busy1, done1, pass1;
  logic        a2, b2, cin2, sum2, cout2, busy2, done2, pass2;
  logic [15:0] vec1, err1, vec2, err2;
  logic [1:0]  fa1_q1, fa1_q2, fa2_q1, fa2_q2;
  int          mode1 = 0;  // 0 normal, 1 sum stuck at 0, 2 two-cycle adder

  int   n_checks = 0;
  int   n_fail = 0;
  res_t exp_q1[$];
  res_t exp_q2[$];
  logic [2:0] vec_q[$];
  int   bl1 = 0, bl2 = 0;
  logic done1_prev = 1'b0, done2_prev = 1'b0;

  always #5 clk = ~clk;

  fulladder_bist #(.N_VECTORS(8), .LATENCY(1), .LFSR_SEED(8'hA5), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a1), .b(b1), .cin(cin1),
    .sum_in(sum1), .cout_in(cout1), .busy(busy1), .done(done1), .pass(pass1),
    .vec_cnt(vec1), .err_cnt(err1)
  );

  fulladder_bist #(.N_VECTORS(8), .LATENCY(2), .LFSR_SEED(8'hA5), .CNT_W(16)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a2), .b(b2), .cin(cin2),
    .sum_in(sum2), .cout_in(cout2), .busy(busy2), .done(done2), .pass(pass2),
    .vec_cnt(vec2), .err_cnt(err2)
  );

  // Behavioural registered adders
  always @(posedge clk) begin
    fa1_q1 <= full_add(a1, b1, cin1);
    fa1_q2 <= fa1_q1;
    fa2_q1 <= full_add(a2, b2, cin2);
    fa2_q2 <= fa2_q1;
  end

  assign {cout1, sum1} = (mode1 == 2) ? fa1_q2 : (mode1 == 1) ? {fa1_q1[1], 1'b0} : fa1_q1;
  assign {cout2, sum2} = fa2_q2;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got an output with no expectation queued at %0t", name, $time);
  endtask

  // Monitor for instance 1: vector sequence, idle/drain outputs, end-of-run results
  always @(negedge clk) begin
    res_t e;
    if (!reset_n) begin
      bl1 = 0;
    end else begin
      if (busy1) begin
        if (bl1 < 8) begin
          if (vec_q.size() > 0) check("vector", 32'({cin1, b1, a1}), 32'(vec_q.pop_front()));
          else miss("vector");
        end else begin
          check("drain_abc", 32'({cin1, b1, a1}), 32'd0);
        end
        bl1++;
      end else begin
        check("idle_abc", 32'({cin1, b1, a1}), 32'd0);
      end
      if (done1 && !done1_prev) begin
        if (exp_q1.size() > 0) begin
          e = exp_q1.pop_front();
          check("dut1_vec_cnt", 32'(vec1), e.vec);
          check("dut1_err_cnt", 32'(err1), e.err);
          check("dut1_pass", 32'(pass1), e.pass);
          check("dut1_busy_len", bl1, e.busy);
        end else begin
          miss("dut1_result");
        end
        bl1 = 0;
      end
    end
    done1_prev = done1;
  end

  // Monitor for instance 2 (LATENCY 2 with a matching adder)
  always @(negedge clk) begin
    res_t e;
    if (!reset_n) begin
      bl2 = 0;
    end else begin
      if (busy2) bl2++;
      if (done2 && !done2_prev) begin
        if (exp_q2.size() > 0) begin
          e = exp_q2.pop_front();
          check("dut2_vec_cnt", 32'(vec2), e.vec);
          check("dut2_err_cnt", 32'(err2), e.err);
          check("dut2_pass", 32'(pass2), e.pass);
          check("dut2_busy_len", bl2, e.busy);
        end else begin
          miss("dut2_result");
        end
        bl2 = 0;
      end
    end
    done2_prev = done2;
  end

  // Queue expectations, issue start, check counters cleared in the first RUN cycle
  task automatic start_run(input res_t e1, input bit hold);
    exp_q1.push_back(e1);
    exp_q2.push_back('{8, 0, 1, 10});
    for (int i = 0; i < 8; i++) vec_q.push_back(VEC_TAB[i]);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 if (!hold) start = 1'b0;
    @(negedge clk);
    check("start_vec_cnt", 32'(vec1), 32'd0);
    check("start_err_cnt", 32'(err1), 32'd0);
    check("start_done", 32'(done1), 32'd0);
    check("start_pass", 32'(pass1), 32'd0);
    check("start_busy", 32'(busy1), 32'd1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done1 && done2) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with start asserted: everything cleared, no run begins
    reset_n = 1'b0;
    start   = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("rst_abc", 32'({cin1, b1, a1}), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_pass", 32'(pass1), 32'd0);
    check("rst_vec_cnt", 32'(vec1), 32'd0);
    check("rst_err_cnt", 32'(err1), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_no_run", 32'({busy1, busy2}), 32'd0);

    // Loopback from IDLE; verdict held stable in DONE
    start_run('{8, 0, 1, 9}, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    check("hold_done", 32'(done1), 32'd1);
    check("hold_pass", 32'(pass1), 32'd1);

    // Restart from DONE with a start pulse mid-RUN that must be ignored
    start_run('{8, 0, 1, 9}, 1'b0);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();

    // Sum stuck at 0
    mode1 = 1;
    start_run('{8, ERR_STUCK, 0, 9}, 1'b0);
    wait_done();

    // Two-cycle adder against LATENCY=1 (instance 2 runs matched)
    mode1 = 2;
    repeat (3) @(negedge clk);
    start_run('{8, ERR_LAT, 0, 9}, 1'b0);
    wait_done();
    mode1 = 0;
    repeat (3) @(negedge clk);

    // Start held high through a whole run: one run only
    start_run('{8, 0, 1, 9}, 1'b1);
    wait_done();
    repeat (4) @(negedge clk);
    check("held_no_restart_done", 32'(done1), 32'd1);
    check("held_no_restart_busy", 32'(busy2), 32'd0);
    check("held_vec_cnt", 32'(vec1), 32'd8);
    @(posedge clk);
    #1 start = 1'b0;

    // Reset in the 4th RUN cycle aborts the run
    start_run('{8, 0, 1, 9}, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q1.delete();
    exp_q2.delete();
    vec_q.delete();
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_abc", 32'({cin1, b1, a1}), 32'd0);
    check("abort_busy", 32'({busy1, busy2}), 32'd0);
    check("abort_vec_cnt", 32'(vec1), 32'd0);
    check("abort_err_cnt", 32'(err1), 32'd0);
    check("abort_done", 32'(done1), 32'd0);

    // A later run is complete and clean
    repeat (2) @(negedge clk);
    start_run('{8, 0, 1, 9}, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);

    check("left_results1", exp_q1.size(), 32'd0);
    check("left_results2", exp_q2.size(), 32'd0);
    check("left_vectors", vec_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
